// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Serial double-dabble binary-to-BCD converter for the display path. One input
// bit is consumed per clock, so a WIDTH-bit word takes WIDTH shift cycles plus
// one DONE cycle. Signed inputs are converted as sign + magnitude. Results that
// do not fit in DIGITS decimal digits are flagged and reported modulo
// 10^DIGITS.
//
// Optional feature macro: BIN2BCD_SEQ_BLANK_EN
//   Defined   : blank[] carries a leading-zero blank mask (blank[0] never set,
//               whole mask cleared on overflow).
//   Undefined : blank[] is tied to all zeros and no blank logic is built.
//
// Parameters
//   WIDTH  : input word width, >= 2
//   DIGITS : number of BCD output digits, >= 1
//   SIGNED : 1 = bin is two's complement, 0 = bin is unsigned
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, accepted in IDLE and in the DONE cycle
//   bin    in   input word, sampled only on the accepting edge
//   busy   out  conversion in progress (SHIFT or DONE)
//   done   out  one-cycle pulse, results valid from this cycle on
//   bcd    out  magnitude as BCD, digit 0 in bits [3:0]
//   neg    out  input was negative (always 0 when SIGNED = 0)
//   ovf    out  magnitude >= 10^DIGITS
//   blank  out  per-digit leading-zero blank mask
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [DIGITS*4-1:0] bcd,
    output logic                neg,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);

    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh;          // remaining binary bits, MSB shifts out first
    logic [BW-1:0]    acc;         // BCD accumulator
    logic [CW-1:0]    cnt;         // shift cycles left minus one
    logic             neg_pend;    // sign of the word being converted
    logic             ovf_sticky;  // a carry has left the top digit

    logic             accept;
    logic             bin_neg;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    acc_adj;
    logic [BW-1:0]    acc_nxt;
    logic [WIDTH-1:0] sh_nxt;
    logic             ovf_nxt;
    logic             last_shift;

    // Both outputs decode the state register only, so they carry no
    // combinational path from the inputs. DONE always leaves after one cycle,
    // which keeps done a single-cycle pulse.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_shift = (state == S_SHIFT) && (cnt == '0);

    // Unary minus wraps modulo 2^WIDTH, so the most negative input yields
    // the correct unsigned magnitude 2^(WIDTH-1).
    assign bin_neg = (SIGNED != 0) && bin[WIDTH-1];
    assign mag     = bin_neg ? -bin : bin;

    // One double-dabble step: correct each digit, then shift left by one.
    // The bit leaving the top digit is dropped from the accumulator, which
    // leaves the result modulo 10^DIGITS, and is folded into the sticky.
    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // update; a path that leaves a signal unassigned would infer a latch.
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
        acc_nxt = {acc_adj[BW-2:0], sh[WIDTH-1]};
        sh_nxt  = {sh[WIDTH-2:0], 1'b0};
        ovf_nxt = ovf_sticky | acc_adj[BW-1];
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sh         <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg_pend   <= 1'b0;
            ovf_sticky <= 1'b0;
            bcd        <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (accept) begin
                sh         <= mag;
                neg_pend   <= bin_neg;
                acc        <= '0;
                ovf_sticky <= 1'b0;
                cnt        <= CW'(WIDTH - 1);
                state      <= S_SHIFT;
            end else begin
                case (state)
                    S_SHIFT: begin
                        sh         <= sh_nxt;
                        acc        <= acc_nxt;
                        ovf_sticky <= ovf_nxt;
                        cnt        <= cnt - CW'(1);
                        if (cnt == '0) begin
                            // Results are published on the edge into DONE so
                            // they are already visible while done is high.
                            state <= S_DONE;
                            bcd   <= acc_nxt;
                            neg   <= neg_pend;
                            ovf   <= ovf_nxt;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    S_IDLE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef BIN2BCD_SEQ_BLANK_EN
    // Reset mask shows a single "0": all digits blanked except digit 0.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_nxt;

    // Scan from the top digit down; a digit is blanked while every digit at
    // or above it is zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (acc_nxt[i*4 +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
        blank_nxt[0] = 1'b0;
        if (ovf_nxt) begin
            blank_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= BLANK_RST;
        end else if (last_shift) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Self-checking bench for bin2bcd_seq. Two instances share clock and reset:
//   dut_a : WIDTH=16, DIGITS=5, SIGNED=1
//   dut_b : WIDTH=10, DIGITS=3, SIGNED=0
// A table of directed vectors is run through either instance, followed by
// hand-written sequences for back-to-back starts, ignored starts, input
// changes during SHIFT and an asynchronous reset mid-conversion.
// Expected blank masks depend on BIN2BCD_SEQ_BLANK_EN.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SEQ_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic        start_a, start_b;
    logic [15:0] bin_a;
    logic [9:0]  bin_b;
    logic        busy_a, done_a, neg_a, ovf_a;
    logic        busy_b, done_b, neg_b, ovf_b;
    logic [19:0] bcd_a;
    logic [11:0] bcd_b;
    logic [4:0]  blank_a;
    logic [2:0]  blank_b;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .neg(neg_a),
        .ovf(ovf_a), .blank(blank_a)
    );

    bin2bcd_seq #(.WIDTH(10), .DIGITS(3), .SIGNED(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .neg(neg_b),
        .ovf(ovf_b), .blank(blank_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One conversion on instance sel (0 = a, 1 = b). start is pulsed on edge A
    // and bin is scrambled right after it; cycle k is cycle A+k.
    task automatic run(input int sel, input logic [15:0] value,
                       output int done_at, output int ndone, output int nbusy,
                       output logic [19:0] r_bcd, output logic r_neg,
                       output logic r_ovf, output logic [4:0] r_blank);
        int w;
        w = (sel == 0) ? 16 : 10;
        done_at = 0; ndone = 0; nbusy = 0;
        r_bcd = '0; r_neg = 1'b0; r_ovf = 1'b0; r_blank = '0;
        if (sel == 0) begin start_a = 1'b1; bin_a = value; end
        else          begin start_b = 1'b1; bin_b = value[9:0]; end
        for (int k = 1; k <= w + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_a = 1'b0; start_b = 1'b0;
                bin_a = ~value; bin_b = ~value[9:0];
            end
            if ((sel == 0) ? busy_a : busy_b) nbusy++;
            if ((sel == 0) ? done_a : done_b) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = k;
                    if (sel == 0) begin
                        r_bcd = bcd_a; r_neg = neg_a; r_ovf = ovf_a; r_blank = blank_a;
                    end else begin
                        r_bcd = {8'h00, bcd_b}; r_neg = neg_b; r_ovf = ovf_b;
                        r_blank = {2'b00, blank_b};
                    end
                end
            end
        end
    endtask

    typedef struct {
        int          sel;
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        logic [4:0]  blank;   // expected mask when the blank feature is built
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    initial begin
        int          done_at, ndone, nbusy, w;
        logic [19:0] r_bcd;
        logic        r_neg, r_ovf;
        logic [4:0]  r_blank, exp_blank;

        vecs[0]  = '{0, 16'h04D2, 20'h01234, 1'b0, 1'b0, 5'b10000};
        vecs[1]  = '{0, 16'hFFFF, 20'h00001, 1'b1, 1'b0, 5'b11110};
        vecs[2]  = '{0, 16'h8000, 20'h32768, 1'b1, 1'b0, 5'b00000};
        vecs[3]  = '{0, 16'h7FFF, 20'h32767, 1'b0, 1'b0, 5'b00000};
        vecs[4]  = '{0, 16'h0000, 20'h00000, 1'b0, 1'b0, 5'b11110};
        vecs[5]  = '{0, 16'hFB2E, 20'h01234, 1'b1, 1'b0, 5'b10000};
        vecs[6]  = '{0, 16'h0009, 20'h00009, 1'b0, 1'b0, 5'b11110};
        vecs[7]  = '{0, 16'h000A, 20'h00010, 1'b0, 1'b0, 5'b11100};
        vecs[8]  = '{1, 16'd999,  20'h00999, 1'b0, 1'b0, 5'b00000};
        vecs[9]  = '{1, 16'd1000, 20'h00000, 1'b0, 1'b1, 5'b00000};
        vecs[10] = '{1, 16'd1023, 20'h00023, 1'b0, 1'b1, 5'b00000};
        vecs[11] = '{1, 16'd0,    20'h00000, 1'b0, 1'b0, 5'b00110};
        vecs[12] = '{1, 16'd5,    20'h00005, 1'b0, 1'b0, 5'b00110};
        vecs[13] = '{1, 16'd100,  20'h00100, 1'b0, 1'b0, 5'b00000};
        vecs[14] = '{1, 16'd512,  20'h00512, 1'b0, 1'b0, 5'b00000};

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        bin_a = '0; bin_b = '0;
        repeat (3) @(negedge clk);

        // Reset state, checked while still in reset and after release.
        check("rst_busy_a",  busy_a,  1'b0);
        check("rst_done_a",  done_a,  1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_bcd_a",   bcd_a,   20'h0);
        check("rst_neg_a",   neg_a,   1'b0);
        check("rst_ovf_a",   ovf_a,   1'b0);
        check("rst_blank_a", blank_a, BLANK_EN ? 5'b11110 : 5'b00000);
        check("rst_busy_b",  busy_b,  1'b0);
        check("rst_bcd_b",   bcd_b,   12'h0);
        check("rst_blank_b", blank_b, BLANK_EN ? 3'b110 : 3'b000);

        // Table-driven single conversions.
        for (int i = 0; i < NV; i++) begin
            w = (vecs[i].sel == 0) ? 16 : 10;
            exp_blank = BLANK_EN ? vecs[i].blank : 5'b00000;
            run(vecs[i].sel, vecs[i].bin, done_at, ndone, nbusy,
                r_bcd, r_neg, r_ovf, r_blank);
            check($sformatf("v%0d_done_at", i), done_at, w + 1);
            check($sformatf("v%0d_done_cnt", i), ndone, 1);
            check($sformatf("v%0d_busy_cyc", i), nbusy, w + 1);
            check($sformatf("v%0d_bcd", i), r_bcd, vecs[i].bcd);
            check($sformatf("v%0d_neg", i), r_neg, vecs[i].neg);
            check($sformatf("v%0d_ovf", i), r_ovf, vecs[i].ovf);
            check($sformatf("v%0d_blank", i), r_blank, exp_blank);
            // Outputs hold in IDLE after the conversion.
            if (vecs[i].sel == 0) check($sformatf("v%0d_hold", i), bcd_a, vecs[i].bcd);
            else                  check($sformatf("v%0d_hold", i), bcd_b, vecs[i].bcd[11:0]);
        end

        // start held high: a new word is latched in each DONE cycle.
        begin
            logic [15:0] nbin [3];
            logic [19:0] ebcd [3];
            logic        eneg [3];
            int          cnt_done;
            nbin = '{16'h04D2, 16'h0009, 16'hFFFF};
            ebcd = '{20'h01234, 20'h00009, 20'h00001};
            eneg = '{1'b0, 1'b0, 1'b1};
            cnt_done = 0;
            start_a = 1'b1;
            bin_a   = nbin[0];
            for (int k = 1; k <= 70; k++) begin
                @(negedge clk);
                if (done_a) begin
                    if (cnt_done < 3) begin
                        check($sformatf("b2b%0d_at", cnt_done), k, 17 * (cnt_done + 1));
                        check($sformatf("b2b%0d_bcd", cnt_done), bcd_a, ebcd[cnt_done]);
                        check($sformatf("b2b%0d_neg", cnt_done), neg_a, eneg[cnt_done]);
                    end
                    cnt_done++;
                    if (cnt_done < 3) bin_a = nbin[cnt_done];
                    else              start_a = 1'b0;
                end
            end
            check("b2b_done_count", cnt_done, 3);
            check("b2b_idle_after", busy_a, 1'b0);
        end

        // start pulse and bin change during SHIFT are both ignored.
        begin
            int cnt_done, first_at;
            cnt_done = 0; first_at = 0;
            start_a = 1'b1;
            bin_a   = 16'h04D2;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == 1)  start_a = 1'b0;
                if (k == 5)  begin start_a = 1'b1; bin_a = 16'h0777; end
                if (k == 6)  start_a = 1'b0;
                if (k == 10) bin_a = 16'h1111;
                if (done_a) begin
                    cnt_done++;
                    if (first_at == 0) first_at = k;
                end
                if (k == 19) check("ign_idle_k19", busy_a, 1'b0);
            end
            check("ign_done_count", cnt_done, 1);
            check("ign_done_at", first_at, 17);
            check("ign_bcd", bcd_a, 20'h01234);
            check("ign_neg", neg_a, 1'b0);
        end

        // Asynchronous reset in cycle A+8 aborts the conversion.
        run(0, 16'h8000, done_at, ndone, nbusy, r_bcd, r_neg, r_ovf, r_blank);
        check("pre_rst_bcd", bcd_a, 20'h32768);
        check("pre_rst_neg", neg_a, 1'b1);
        begin
            int cnt_done;
            cnt_done = 0;
            start_a = 1'b1;
            bin_a   = 16'hFFFF;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k == 1) start_a = 1'b0;
            end
            check("mid_busy_before", busy_a, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            check("ar_busy",  busy_a,  1'b0);
            check("ar_done",  done_a,  1'b0);
            check("ar_bcd",   bcd_a,   20'h0);
            check("ar_neg",   neg_a,   1'b0);
            check("ar_ovf",   ovf_a,   1'b0);
            check("ar_blank", blank_a, BLANK_EN ? 5'b11110 : 5'b00000);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int k = 1; k <= 25; k++) begin
                @(negedge clk);
                if (done_a || busy_a) cnt_done++;
            end
            check("ar_no_done", cnt_done, 0);
        end
        run(0, 16'h0000, done_at, ndone, nbusy, r_bcd, r_neg, r_ovf, r_blank);
        check("post_rst_done_at", done_at, 17);
        check("post_rst_bcd",     r_bcd,   20'h0);
        check("post_rst_blank",   r_blank, BLANK_EN ? 5'b11110 : 5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter for the display path. It runs a serial double-dabble, one input bit per clock. It handles signed or unsigned input of any width, flags results too large for the configured digit count, and reports completion with a start/done handshake. It sits between the arithmetic datapath and the seven-segment digit drivers, and replaces combinational conversion where wide inputs would make the logic too deep.

## Interface
- `WIDTH`, 16: input word width in bits, minimum 2.
- `DIGITS`, 5: number of BCD output digits, minimum 1.
- `SIGNED`, 1: 1 = `bin` is two's complement; 0 = `bin` is unsigned.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a conversion; accepted only while `busy` = 0.
- `bin`  in  `WIDTH`: input value; sampled only on the accepting edge.
- `busy`  out  1: a conversion is in progress.
- `done`  out  1: one-cycle pulse; results are valid from this cycle on.
- `bcd`  out  `DIGITS*4`: magnitude, with digit 0 in bits [3:0].
- `neg`  out  1: input was negative (`SIGNED` = 1 only; otherwise held at 0).
- `ovf`  out  1: magnitude ≥ 10^`DIGITS`.
- `blank`  out  `DIGITS`: per-digit leading-zero blank mask (see Configuration).

## Operation
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `neg`, `ovf` = 0.
  - `bcd` = 0.
  - `blank` = {`DIGITS`-1 ones, 0} with the macro, all 0 without it.
- States: IDLE, SHIFT, DONE.
- **IDLE**, `start` = 1:
  - Latch magnitude into a `WIDTH`-bit shift register. If `SIGNED` and `bin[WIDTH-1]`, the magnitude is `-bin` modulo 2^`WIDTH`, read as unsigned, so `-2^(WIDTH-1)` converts correctly.
  - Latch the sign into a pending register.
  - Clear the BCD accumulator and the overflow sticky.
  - Counter = `WIDTH`-1. Go to SHIFT.
- **SHIFT**, each cycle:
  - For every digit ≥ 5, add 3 to that digit.
  - Shift {accumulator, shift register} left by one.
  - If the bit shifted out of the top digit is 1, set the overflow sticky.
  - Decrement the counter. When it reaches 0, go to DONE.
  - Exactly `WIDTH` SHIFT cycles occur.
- **DONE**, one cycle:
  - Copy accumulator → `bcd`, pending sign → `neg`, sticky → `ovf`, and compute `blank`.
  - Assert `done`.
  - Next state: SHIFT if `start` = 1 (back-to-back conversion, same latch actions as IDLE); otherwise IDLE.
- On overflow, `bcd` holds the low `DIGITS` decimal digits of the magnitude, i.e. the magnitude mod 10^`DIGITS`.
- `bcd`, `neg`, `ovf`, `blank` change only in DONE. Between conversions they hold their last values.
- `start` during SHIFT is ignored: it is not queued, and no error is raised.
- `bin` changing after the accepting edge has no effect.
- Reset asserted mid-conversion aborts immediately. All outputs return to reset values, and no `done` is issued.

## Timing
- Accept edge: edge A. `busy` = 1 for cycles A+1 … A+`WIDTH`+1.
- `done` = 1 and new outputs are visible in cycle A+`WIDTH`+1, registered with no combinational path from the inputs.
- Latency from the `start` edge to `done`: `WIDTH`+1 cycles.
- `busy` = 1 in SHIFT and DONE; `busy` = 0 in IDLE.
- `start` is also accepted in the DONE cycle, even though `busy` = 1 there. This is the only exception to the `busy` = 0 rule.
- Sustained throughput: one result per `WIDTH`+1 cycles.
- `done` is never high for two consecutive cycles.

## Configuration
- Macro: `BIN2BCD_SEQ_BLANK_EN`.
- **Defined:**
  - In DONE, `blank[i]` = 1 iff digit i and every digit above it are 0, for i ≥ 1.
  - `blank[0]` is always 0, so zero displays as a single "0".
  - When `ovf` = 1, `blank` is forced to all 0.
- **Undefined:**
  - The blank logic is not synthesised; `blank` is tied to all 0.
  - All other behaviour is identical.

## Test plan
- `WIDTH`=16, `DIGITS`=5, `SIGNED`=1, `bin`=16'h04D2, `start` pulse at edge A:
  - `done` at cycle A+17 only.
  - `bcd`=20'h01234, `neg`=0, `ovf`=0.
  - `blank`=5'b10000 with the macro.
- Same config, signed extremes:
  - `bin`=16'hFFFF → `bcd`=20'h00001, `neg`=1.
  - `bin`=16'h8000 → `bcd`=20'h32768, `neg`=1, `ovf`=0.
- `WIDTH`=10, `DIGITS`=3, `SIGNED`=0, overflow boundary:
  - `bin`=999 → `bcd`=12'h999, `ovf`=0.
  - `bin`=1000 → `bcd`=12'h000, `ovf`=1, `blank`=3'b000.
- Handshake corners:
  - `start` held high continuously → `done` pulses every 17 cycles with correct results.
  - A `start` pulse mid-SHIFT is ignored.
  - Changing `bin` mid-SHIFT does not alter the result.
- Reset during conversion: `rst_n` low at cycle A+8, asynchronous, between edges.
  - `busy` = 0 immediately, with no `done`.
  - Outputs return to reset values.
  - A later conversion of `bin`=0 gives `bcd`=0 and `blank`=5'b11110 with the macro.
